// File: rtl/pokey_kbd_pkg.sv
// ============================================================================
// pokey_kbd_pkg : shared types and PS/2 / Atari constants for the keyboard matrix
// Rev 1.0
// ============================================================================
`default_nettype none

package pokey_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BRK    = 3'd1,
    ST_EXT    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } parse_state_e;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CTRL   = 8'h14;
  localparam logic [7:0] PS2_F12    = 8'h07;

  localparam logic [5:0] ATARI_CTRL  = 6'h00;
  localparam logic [5:0] ATARI_SHIFT = 6'h10;
  localparam logic [5:0] ATARI_BREAK = 6'h30;

  // Bytes following E1 in the Pause/Break make sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pokey_ps2_keymap.sv
// ============================================================================
// pokey_ps2_keymap : combinational PS/2 set-2 to Atari key-code ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module pokey_ps2_keymap
  import pokey_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [5:0] atari_code
);

  always_comb begin
    hit        = 1'b1;
    atari_code = 6'h00;
    case ({ext, code})
      9'h01C: atari_code = 6'h3F;  // A
      9'h032: atari_code = 6'h15;  // B
      9'h021: atari_code = 6'h12;  // C
      9'h023: atari_code = 6'h3A;  // D
      9'h024: atari_code = 6'h2A;  // E
      9'h02B: atari_code = 6'h38;  // F
      9'h034: atari_code = 6'h3D;
      9'h033: atari_code = 6'h39;
      9'h043: atari_code = 6'h0D;
      9'h03B: atari_code = 6'h01;
      9'h042: atari_code = 6'h05;
      9'h04B: atari_code = 6'h00;  // L
      9'h03A: atari_code = 6'h25;
      9'h031: atari_code = 6'h23;
      9'h044: atari_code = 6'h08;
      9'h04D: atari_code = 6'h0A;
      9'h015: atari_code = 6'h2F;
      9'h02D: atari_code = 6'h28;
      9'h01B: atari_code = 6'h3E;  // S
      9'h02C: atari_code = 6'h2D;
      9'h03C: atari_code = 6'h0B;
      9'h02A: atari_code = 6'h10;
      9'h01D: atari_code = 6'h2E;
      9'h022: atari_code = 6'h16;
      9'h035: atari_code = 6'h2B;
      9'h01A: atari_code = 6'h17;  // Z
      9'h016: atari_code = 6'h1F;  // 1
      9'h01E: atari_code = 6'h1E;
      9'h026: atari_code = 6'h1A;
      9'h025: atari_code = 6'h18;
      9'h02E: atari_code = 6'h1D;
      9'h036: atari_code = 6'h1B;
      9'h03D: atari_code = 6'h33;
      9'h03E: atari_code = 6'h35;
      9'h046: atari_code = 6'h30;
      9'h045: atari_code = 6'h32;  // 0
      9'h04E: atari_code = 6'h0E;  // -
      9'h055: atari_code = 6'h0F;  // =
      9'h04C: atari_code = 6'h02;  // ;
      9'h041: atari_code = 6'h20;  // ,
      9'h049: atari_code = 6'h22;  // .
      9'h04A: atari_code = 6'h26;  // /
      9'h029: atari_code = 6'h21;  // Space
      9'h05A: atari_code = 6'h0C;  // Return
      9'h066: atari_code = 6'h34;  // Backspace
      9'h00D: atari_code = 6'h2C;  // Tab
      9'h076: atari_code = 6'h1C;  // Esc
      9'h058: atari_code = 6'h3C;  // Caps
      9'h00E: atari_code = 6'h27;  // ` -> Inverse
      9'h078: atari_code = 6'h11;  // F11 -> Help
      9'h15A: atari_code = 6'h0C;  // keypad Enter
      9'h14A: atari_code = 6'h26;  // keypad /
      9'h171: atari_code = 6'h34;  // Delete
      default: hit = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pokey_keyboard_matrix.sv
// ============================================================================
// pokey_keyboard_matrix : PS/2 set-2 decoder presenting an Atari 8x8 key matrix
// Rev 1.0
// ============================================================================
`default_nettype none

module pokey_keyboard_matrix
  import pokey_kbd_pkg::*;
#(
  parameter int EXT_ENABLE    = 1,
  parameter int STUCK_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic [5:0] keyboard_scan,
  output logic [1:0] keyboard_response,
  output logic       any_key
);

  localparam logic EXT_ON = (EXT_ENABLE != 0);

  parse_state_e state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic [63:0]  key_map_q, key_map_d;
  logic         lshift_q, lshift_d, rshift_q, rshift_d;
  logic         lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic         brk_q, brk_d;
  logic         any_key_q, any_key_d;

  logic         held;
  logic         expire;
  logic         clear_all;
  logic         ev_valid, ev_make, ev_ext;
  logic         km_hit;
  logic [5:0]   km_code;
  logic [5:0]   idx;
  logic         mod_low;

  pokey_ps2_keymap u_keymap (
    .ext        (ev_ext),
    .code       (ps2_data),
    .hit        (km_hit),
    .atari_code (km_code)
  );

  // With extensions disabled the E0 states still track the sequence so the
  // following byte(s) are swallowed, but they never produce an event.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    ev_valid  = 1'b0;
    ev_make   = 1'b0;
    clear_all = expire;
    ev_ext    = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_data == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (ps2_data == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (is_overrun(ps2_data)) begin
            clear_all = 1'b1;
          end else if (!is_ignored(ps2_data)) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_data == PS2_BRK) begin
            state_d = ST_EXTBRK;
          end else begin
            ev_valid = EXT_ON;
            ev_make  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_valid = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXTBRK: begin
          ev_valid = EXT_ON;
          state_d  = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_map_d = key_map_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    lctrl_d   = lctrl_q;
    rctrl_d   = rctrl_q;
    brk_d     = brk_q;
    if (clear_all) begin
      key_map_d = '0;
      lshift_d  = 1'b0;
      rshift_d  = 1'b0;
      lctrl_d   = 1'b0;
      rctrl_d   = 1'b0;
      brk_d     = 1'b0;
    end else if (ev_valid) begin
      if (!ev_ext && ps2_data == PS2_LSHIFT) begin
        lshift_d = ev_make;
      end else if (!ev_ext && ps2_data == PS2_RSHIFT) begin
        rshift_d = ev_make;
      end else if (!ev_ext && ps2_data == PS2_CTRL) begin
        lctrl_d = ev_make;
      end else if (ev_ext && ps2_data == PS2_CTRL) begin
        rctrl_d = ev_make;
      end else if (!ev_ext && ps2_data == PS2_F12) begin
        brk_d = ev_make;
      end else if (km_hit) begin
        key_map_d[km_code] = ev_make;
      end
    end
  end

  assign held      = (|key_map_q) | lshift_q | rshift_q | lctrl_q | rctrl_q | brk_q;
  assign any_key_d = held;
  assign any_key   = any_key_q;

  generate
    if (STUCK_TIMEOUT > 0) begin : g_timeout
      localparam int         TW   = (STUCK_TIMEOUT > 1) ? $clog2(STUCK_TIMEOUT + 1) : 1;
      localparam logic [TW-1:0] LAST = TW'(STUCK_TIMEOUT - 1);
      logic [TW-1:0] cnt_q, cnt_d;

      // A byte in the expiry cycle wins: expire is masked and the count restarts.
      assign expire = held && !ps2_valid && (cnt_q == LAST);

      always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (ps2_valid || !held || expire) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    idx     = ~keyboard_scan;
    mod_low = ((idx == ATARI_CTRL)  && (lctrl_q | rctrl_q)) ||
              ((idx == ATARI_SHIFT) && (lshift_q | rshift_q)) ||
              ((idx == ATARI_BREAK) && brk_q);
    keyboard_response = {~mod_low, ~key_map_q[idx]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      skip_q    <= 3'd0;
      key_map_q <= '0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      lctrl_q   <= 1'b0;
      rctrl_q   <= 1'b0;
      brk_q     <= 1'b0;
      any_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      key_map_q <= key_map_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      lctrl_q   <= lctrl_d;
      rctrl_q   <= rctrl_d;
      brk_q     <= brk_d;
      any_key_q <= any_key_d;
    end
  end

endmodule

`default_nettype wire
